say_rr_arbiter: RTL
===================

Name: say_rr_arbiter

Overview:
- Shares one downstream say method (704-bit payload, ENA/RDY method protocol) among NREQ requesters, e.g. several producers feeding one IVector-style say port.
- Round-robin arbitration with an optional burst lock, so one requester may issue up to BURST back-to-back transfers.
- A one-entry staging register decouples requester RDY from downstream RDY timing (1-cycle latency).
- Exports the source ID of the staged beat and a transfer counter for debug.

Parameters:
NREQ, 4, number of requesters (2..16); SRCW = ceil(log2(NREQ)).
DATA_WIDTH, 704, say payload width.
BURST, 4, max consecutive grants to one requester (1..255); 1 gives pure round-robin.

Ports:
CLK  input  1  clock
nRST  input  1  reset; asynchronous, active-low
req_want  input  NREQ  bit i: requester i has a transfer pending
req_say__ENA  input  NREQ  bit i: requester i fires say; asserted only while req_say__RDY[i]
req_say_v  input  NREQ*DATA_WIDTH  payload, slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
req_say__RDY  output  NREQ  bit i: requester i may fire this cycle
out_say__ENA  output  1  downstream say fire
out_say_v  output  DATA_WIDTH  staged payload
out_say__RDY  input  1  downstream say ready
out_src  output  SRCW  requester index of staged payload
busy  output  1  staging register full
xfer_count  output  32  count of downstream fires

Behaviour:
- Reset (async, nRST low): full=0, out_src=0, out_say_v=0, rr_ptr=0, lock_valid=0, lock_id=0, burst_cnt=0, xfer_count=0. All RDY/ENA outputs are 0 while in reset.
- accept_ok = !full || out_say__RDY. This allows same-cycle drain and refill.
- Grant selection, combinational:
  - If lock_valid && req_want[lock_id], grant = lock_id.
  - Otherwise grant = first i with req_want[i], searching from rr_ptr upward with wrap modulo NREQ.
  - No want bits set: no grant.
- req_say__RDY[i] = accept_ok && grant_valid && grant==i. Exactly one RDY bit is high at most. RDY never depends on req_say__ENA.
- in_fire = req_say__ENA[grant] && req_say__RDY[grant]. An ENA bit asserted without its RDY is ignored: no state change.
- On in_fire at edge t:
  - out_say_v <= slice grant; out_src <= grant; full <= 1.
  - Payload is visible from cycle t+1, so latency is 1 cycle.
- Burst update on in_fire:
  - If lock_valid && grant==lock_id: burst_cnt <= burst_cnt+1.
  - Else: lock_id <= grant, burst_cnt <= 1, lock_valid <= 1.
  - If the new burst_cnt == BURST: lock_valid <= 0, burst_cnt <= 0, rr_ptr <= (grant+1) mod NREQ.
- Lock release without fire: if lock_valid && !req_want[lock_id], then lock_valid <= 0, burst_cnt <= 0, rr_ptr <= (lock_id+1) mod NREQ.
- Downstream side:
  - out_say__ENA = full && out_say__RDY.
  - On out fire without in_fire: full <= 0; out_say_v and out_src hold their values.
  - On out fire with in_fire in the same cycle: full stays 1 and the register takes the new payload; no beat is lost or duplicated.
- xfer_count increments on every out_say__ENA and wraps from 2^32-1 to 0.
- busy = full.
- Full and out_say__RDY=0: all req RDY are 0; staged data and lock state hold.
- Reset mid-operation: the staged beat is discarded, nothing is emitted, and the lock clears.

Test Plan:
- Reset, then want=4'b0000 and out RDY=1 for 5 cycles -> all RDY=0, out ENA=0, xfer_count=0, busy=0.
- BURST=1, want=4'b1111, ENA follows RDY, out RDY=1 -> grants 0,1,2,3,0,...; each payload appears on out_say_v one cycle later with out_src equal to its requester; xfer_count=8 after 8 fires.
- BURST=4, want=4'b0011 held -> requester 0 gets 4 consecutive transfers, then requester 1 gets 4, then requester 0 again.
- BURST=4, requester 2 locked at burst_cnt=2, then want[2] drops -> lock releases; next grant goes to the first wanting requester from index 3.
- out RDY=0 for 3 cycles with a staged beat 0xA5 -> busy=1, all req RDY=0, out_say_v stable at 0xA5. Then out RDY=1 with requester 1 firing 0x5A in the same cycle -> 0xA5 is emitted, 0x5A is staged, busy stays 1.
- Assert nRST low while busy=1 and locked -> outputs reset immediately (async); after release, grant restarts at index 0 and no stale beat is emitted.

Source files
------------

// File: rtl/say_rr_arbiter.sv
// Round-robin arbiter sharing one downstream say method among NREQ requesters,
// with an optional burst lock and a one-entry staging register in front of the output.
module say_rr_arbiter #(
   parameter int unsigned NREQ       = 4,
   parameter int unsigned DATA_WIDTH = 704,
   parameter int unsigned BURST      = 4,
   localparam int unsigned SRCW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic [NREQ-1:0]            req_want,
   input  logic [NREQ-1:0]            req_say__ENA,
   input  logic [NREQ*DATA_WIDTH-1:0] req_say_v,
   output logic [NREQ-1:0]            req_say__RDY,
   output logic                       out_say__ENA,
   output logic [DATA_WIDTH-1:0]      out_say_v,
   input  logic                       out_say__RDY,
   output logic [SRCW-1:0]            out_src,
   output logic                       busy,
   output logic [31:0]                xfer_count
);

   logic                  full_q, full_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [SRCW-1:0]       src_q, src_d;
   logic [SRCW-1:0]       ptr_q, ptr_d;
   logic                  lock_valid_q, lock_valid_d;
   logic [SRCW-1:0]       lock_id_q, lock_id_d;
   logic [7:0]            burst_q, burst_d;
   logic [31:0]           xfer_q, xfer_d;

   logic                  grant_valid;
   logic [SRCW-1:0]       grant;
   logic [DATA_WIDTH-1:0] grant_data;
   logic                  accept_ok;
   logic                  in_fire;
   logic                  out_fire;
   logic [NREQ-1:0]       rdy;
   logic [7:0]            burst_inc;

   function automatic logic [SRCW-1:0] wrap_inc(input logic [SRCW-1:0] x);
      if (x >= SRCW'(NREQ - 1)) begin
         return '0;
      end
      return x + 1'b1;
   endfunction

   // A held lock wins while its owner still wants; otherwise search upward from rr_ptr.
   always_comb begin : grant_sel
      int              idx;
      logic [SRCW-1:0] cand;
      grant_valid = 1'b0;
      grant       = '0;
      idx         = 0;
      cand        = '0;
      if (lock_valid_q && req_want[lock_id_q]) begin
         grant_valid = 1'b1;
         grant       = lock_id_q;
      end else begin
         // Descending scan so the smallest offset from rr_ptr is the last one written.
         for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            idx  = (int'(ptr_q) + k) % int'(NREQ);
            cand = SRCW'(idx);
            if (req_want[cand]) begin
               grant_valid = 1'b1;
               grant       = cand;
            end
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (grant == SRCW'(i)) begin
            grant_data = req_say_v[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign accept_ok = !full_q || out_say__RDY;
   assign rdy       = (nRST && accept_ok && grant_valid) ? (NREQ'(1) << grant) : '0;
   assign in_fire   = grant_valid && rdy[grant] && req_say__ENA[grant];
   assign out_fire  = full_q && out_say__RDY;
   assign burst_inc = burst_q + 8'd1;

   assign req_say__RDY = rdy;
   assign out_say__ENA = out_fire;
   assign out_say_v    = data_q;
   assign out_src      = src_q;
   assign busy         = full_q;
   assign xfer_count   = xfer_q;

   always_comb begin
      full_d       = full_q;
      data_d       = data_q;
      src_d        = src_q;
      ptr_d        = ptr_q;
      lock_valid_d = lock_valid_q;
      lock_id_d    = lock_id_q;
      burst_d      = burst_q;
      xfer_d       = xfer_q;

      if (out_fire) begin
         xfer_d = xfer_q + 32'd1;
      end

      // Refill takes priority over drain so a same-cycle drain+refill keeps full set.
      if (in_fire) begin
         full_d = 1'b1;
         data_d = grant_data;
         src_d  = grant;
      end else if (out_fire) begin
         full_d = 1'b0;
      end

      if (lock_valid_q && !req_want[lock_id_q]) begin
         lock_valid_d = 1'b0;
         burst_d      = 8'd0;
         ptr_d        = wrap_inc(lock_id_q);
      end

      if (in_fire) begin
         if (lock_valid_q && (grant == lock_id_q)) begin
            burst_d = burst_inc;
         end else begin
            lock_id_d    = grant;
            burst_d      = 8'd1;
            lock_valid_d = 1'b1;
         end
         if (burst_d == 8'(BURST)) begin
            lock_valid_d = 1'b0;
            burst_d      = 8'd0;
            ptr_d        = wrap_inc(grant);
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         full_q       <= 1'b0;
         data_q       <= '0;
         src_q        <= '0;
         ptr_q        <= '0;
         lock_valid_q <= 1'b0;
         lock_id_q    <= '0;
         burst_q      <= 8'd0;
         xfer_q       <= 32'd0;
      end else begin
         full_q       <= full_d;
         data_q       <= data_d;
         src_q        <= src_d;
         ptr_q        <= ptr_d;
         lock_valid_q <= lock_valid_d;
         lock_id_q    <= lock_id_d;
         burst_q      <= burst_d;
         xfer_q       <= xfer_d;
      end
   end

`ifndef SYNTHESIS
   a_rdy_onehot: assert property (@(posedge CLK) disable iff (!nRST) $onehot0(req_say__RDY));
   a_ena_full:   assert property (@(posedge CLK) disable iff (!nRST) out_say__ENA |-> busy);
`endif

endmodule
